bp_me_dram_hash_encode_pipe: RTL and testbench

- Pipelined, mode-programmable successor to the combinational DRAM address hasher.
- Sits between the CCE/L2 request path and the L2 slice/bank steering logic.
- Accepts physical addresses with data over a ready/valid handshake and produces a hashed DRAM address plus slice and bank selects.
- Supports three run-time hash modes, zero-width fields and lossless mode switching by drain-and-swap.

---
 rtl/bp_me_dram_hash_encode_pipe_if.sv | 38 +++
 rtl/bp_me_dram_hash_encode_pipe.sv | 190 +++++++++++++++++++
 tb/tb_bp_me_dram_hash_encode_pipe.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_dram_hash_encode_pipe_if.sv
// Request/response bundle for the pipelined DRAM address hasher: config,
// input handshake with address/payload, and the hashed output handshake.
interface bp_me_dram_hash_encode_pipe_if #(
   parameter int paddr_width_p = 40,
   parameter int daddr_width_p = 32,
   parameter int data_width_p  = 64,
   parameter int slice_width_p = 1,
   parameter int bank_width_p  = 2
);
   localparam int slice_w_lp = (slice_width_p > 0) ? slice_width_p : 1;
   localparam int bank_w_lp  = (bank_width_p > 0) ? bank_width_p : 1;

   logic                     cfg_v_i;
   logic [1:0]               cfg_mode_i;
   logic [1:0]               mode_o;
   logic                     busy_o;
   logic                     v_i;
   logic                     ready_and_o;
   logic [paddr_width_p-1:0] paddr_i;
   logic [data_width_p-1:0]  data_i;
   logic                     v_o;
   logic                     ready_and_i;
   logic                     dram_o;
   logic [daddr_width_p-1:0] daddr_o;
   logic [slice_w_lp-1:0]    slice_o;
   logic [bank_w_lp-1:0]     bank_o;
   logic [data_width_p-1:0]  data_o;

   modport slave (
      input  cfg_v_i, cfg_mode_i, v_i, paddr_i, data_i, ready_and_i,
      output mode_o, busy_o, ready_and_o, v_o, dram_o, daddr_o, slice_o, bank_o, data_o
   );

   modport master (
      output cfg_v_i, cfg_mode_i, v_i, paddr_i, data_i, ready_and_i,
      input  mode_o, busy_o, ready_and_o, v_o, dram_o, daddr_o, slice_o, bank_o, data_o
   );
endinterface

// File: rtl/bp_me_dram_hash_encode_pipe.sv
// Pipelined DRAM address hasher: combinational field swizzle/xor on input,
// small output FIFO, and a drain-and-swap FSM for lossless mode changes.
module bp_me_dram_hash_encode_pipe #(
   parameter int                     paddr_width_p = 40,
   parameter int                     daddr_width_p = 32,
   parameter logic [paddr_width_p-1:0] dram_base_p = 40'h0_8000_0000,
   parameter int                     block_width_p = 6,
   parameter int                     cce_width_p   = 1,
   parameter int                     slice_width_p = 1,
   parameter int                     bank_width_p  = 2,
   parameter int                     set_width_p   = 3,
   parameter int                     data_width_p  = 64,
   parameter int                     fifo_els_p    = 2
) (
   input logic                          clk_i,
   input logic                          reset_i,
   bp_me_dram_hash_encode_pipe_if.slave io
);
   localparam int slice_w_lp = (slice_width_p > 0) ? slice_width_p : 1;
   localparam int bank_w_lp  = (bank_width_p > 0) ? bank_width_p : 1;
   localparam int b_lp       = block_width_p;
   localparam int c_lp       = cce_width_p;
   localparam int s_lp       = slice_width_p;
   localparam int t_lp       = set_width_p;
   localparam int h_lp       = cce_width_p + slice_width_p + bank_width_p;
   localparam int tag_w_lp   = daddr_width_p - b_lp - h_lp - t_lp;
   localparam int entry_w_lp = 1 + daddr_width_p + slice_w_lp + bank_w_lp + data_width_p;
   localparam int ptr_w_lp   = $clog2(fifo_els_p);
   localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);

   typedef enum logic [1:0] {e_run, e_drain, e_swap} state_e;

   state_e                   state_reg, state_next;
   logic [1:0]               mode_reg, mode_next;
   logic [1:0]               mode_pending_reg, mode_pending_next;
   logic [1:0]               cfg_mode_norm;
   logic                     rst_sync_reg;

   logic [daddr_width_p-1:0] addr_lo, addr_swz, addr_xor;
   logic [slice_w_lp-1:0]    slice_in, slice_swz, slice_xor;
   logic [bank_w_lp-1:0]     bank_in, bank_swz, bank_xor;
   logic                     hash_dram;
   logic [daddr_width_p-1:0] hash_daddr;
   logic [slice_w_lp-1:0]    hash_slice;
   logic [bank_w_lp-1:0]     hash_bank;

   logic [entry_w_lp-1:0]    mem [fifo_els_p];
   logic [entry_w_lp-1:0]    enq_entry, head_entry;
   logic [ptr_w_lp-1:0]      wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [cnt_w_lp-1:0]      count_reg, count_next;
   logic                     fifo_full, fifo_empty, enq, deq;

   assign addr_lo = io.paddr_i[daddr_width_p-1:0];

   // Output layout [block][set][H][tag]; H={bank,slice,cce} is contiguous in
   // both layouts, so each output bit maps straight to one input bit.
   for (genvar gi = 0; gi < daddr_width_p; gi++) begin : g_bit
      if (gi < b_lp) begin : g_block
         assign addr_swz[gi] = addr_lo[gi];
         assign addr_xor[gi] = addr_lo[gi];
      end else if (gi < b_lp + t_lp) begin : g_set
         assign addr_swz[gi] = addr_lo[gi + h_lp];
         assign addr_xor[gi] = addr_lo[gi + h_lp];
      end else if (gi < b_lp + t_lp + h_lp) begin : g_h
         assign addr_swz[gi] = addr_lo[gi - t_lp];
         if (gi - b_lp - t_lp < tag_w_lp) begin : g_mix
            assign addr_xor[gi] = addr_lo[gi - t_lp] ^ addr_lo[gi + h_lp];
         end else begin : g_nomix
            assign addr_xor[gi] = addr_lo[gi - t_lp];
         end
      end else begin : g_tag
         assign addr_swz[gi] = addr_lo[gi];
         assign addr_xor[gi] = addr_lo[gi];
      end
   end

   if (slice_width_p == 0) begin : g_no_slice
      assign slice_in  = '0;
      assign slice_swz = '0;
      assign slice_xor = '0;
   end else begin : g_slice
      assign slice_in  = addr_lo[b_lp + c_lp +: slice_width_p];
      assign slice_swz = addr_swz[b_lp + t_lp + c_lp +: slice_width_p];
      assign slice_xor = addr_xor[b_lp + t_lp + c_lp +: slice_width_p];
   end

   if (bank_width_p == 0) begin : g_no_bank
      assign bank_in  = '0;
      assign bank_swz = '0;
      assign bank_xor = '0;
   end else begin : g_bank
      assign bank_in  = addr_lo[b_lp + c_lp + s_lp +: bank_width_p];
      assign bank_swz = addr_swz[b_lp + t_lp + c_lp + s_lp +: bank_width_p];
      assign bank_xor = addr_xor[b_lp + t_lp + c_lp + s_lp +: bank_width_p];
   end

   always_comb begin
      hash_dram  = (io.paddr_i >= dram_base_p);
      hash_daddr = addr_lo;
      hash_slice = '0;
      hash_bank  = '0;
      if (hash_dram) begin
         case (mode_reg)
            2'd0: begin
               hash_slice = slice_in;
               hash_bank  = bank_in;
            end
            2'd2: begin
               hash_daddr = addr_xor;
               hash_slice = slice_xor;
               hash_bank  = bank_xor;
            end
            default: begin
               hash_daddr = addr_swz;
               hash_slice = slice_swz;
               hash_bank  = bank_swz;
            end
         endcase
      end
   end

   assign fifo_full  = (count_reg == cnt_w_lp'(fifo_els_p));
   assign fifo_empty = (count_reg == '0);
   assign enq        = io.v_i & io.ready_and_o;
   assign deq        = ~fifo_empty & io.ready_and_i;
   assign enq_entry  = {hash_dram, hash_daddr, hash_slice, hash_bank, io.data_i};
   assign head_entry = mem[rd_ptr_reg];

   assign io.ready_and_o = ~fifo_full & (state_reg == e_run) & rst_sync_reg;
   assign io.v_o         = ~fifo_empty;
   assign io.busy_o      = (state_reg != e_run);
   assign io.mode_o      = mode_reg;
   assign {io.dram_o, io.daddr_o, io.slice_o, io.bank_o, io.data_o} =
      fifo_empty ? '0 : head_entry;

   function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (enq) mem[wr_ptr_reg] <= enq_entry;
   end

   // Reserved mode 3 is folded to swizzle on capture so mode_o reports what is applied.
   assign cfg_mode_norm = (io.cfg_mode_i == 2'd3) ? 2'd1 : io.cfg_mode_i;

   always_comb begin
      wr_ptr_next       = enq ? bump(wr_ptr_reg) : wr_ptr_reg;
      rd_ptr_next       = deq ? bump(rd_ptr_reg) : rd_ptr_reg;
      count_next        = count_reg + cnt_w_lp'(enq) - cnt_w_lp'(deq);
      state_next        = state_reg;
      mode_next         = mode_reg;
      mode_pending_next = io.cfg_v_i ? cfg_mode_norm : mode_pending_reg;
      case (state_reg)
         e_run: begin
            if (io.cfg_v_i) state_next = e_drain;
         end
         e_drain: begin
            if (fifo_empty) begin
               state_next = e_swap;
               mode_next  = mode_pending_next;
            end
         end
         e_swap: begin
            state_next = io.cfg_v_i ? e_drain : e_run;
         end
         default: state_next = e_run;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         state_reg        <= e_run;
         mode_reg         <= 2'd1;
         mode_pending_reg <= 2'd1;
         rst_sync_reg     <= 1'b0;
      end else begin
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         count_reg        <= count_next;
         state_reg        <= state_next;
         mode_reg         <= mode_next;
         mode_pending_reg <= mode_pending_next;
         rst_sync_reg     <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bp_me_dram_hash_encode_pipe.sv
// Randomised and directed bench for the DRAM hash pipe; a field-level
// reference model plus scoreboard queue predicts every output.
module tb_bp_me_dram_hash_encode_pipe;
   typedef struct packed {
      logic        dram;
      logic [31:0] daddr;
      logic [0:0]  slice;
      logic [1:0]  bank;
      logic [63:0] data;
   } txn_t;

   logic clk;
   logic reset_n;
   int   vec_cnt;
   int   err_cnt;
   int   tb_mode;
   txn_t exp_q[$];
   logic popped;
   txn_t pop_exp, pop_got;

   bp_me_dram_hash_encode_pipe_if ifc ();
   bp_me_dram_hash_encode_pipe_if #(.slice_width_p(0)) ifz ();

   bp_me_dram_hash_encode_pipe u_dut (.clk_i(clk), .reset_i(reset_n), .io(ifc.slave));
   bp_me_dram_hash_encode_pipe #(.cce_width_p(0), .slice_width_p(0))
      u_dut_z (.clk_i(clk), .reset_i(reset_n), .io(ifz.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic longint unsigned msk(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   // Fields by shift/mask: block=6, set=3, cce/slice/bank widths c/s/k, 32-bit daddr.
   function automatic txn_t model(input logic [39:0] p, input int mode, input int c,
                                  input int s, input int k);
      txn_t r;
      longint unsigned a, blk, hh, st, tg, d;
      int m, h;
      r = '0;
      h = c + s + k;
      m = (mode == 3) ? 1 : mode;
      a = 64'(p[31:0]);
      r.daddr = p[31:0];
      if (p < 40'h0_8000_0000) return r;
      r.dram = 1'b1;
      if (m == 0) begin
         r.slice = 1'((a >> (6 + c)) & msk(s));
         r.bank  = 2'((a >> (6 + c + s)) & msk(k));
         return r;
      end
      blk = a & msk(6);
      hh  = (a >> 6) & msk(h);
      st  = (a >> (6 + h)) & msk(3);
      tg  = a >> (6 + h + 3);
      if (m == 2) hh = hh ^ (tg & msk(h));
      d = blk | (st << 6) | (hh << 9) | (tg << (9 + h));
      r.daddr = 32'(d);
      r.slice = 1'((hh >> c) & msk(s));
      r.bank  = 2'((hh >> (c + s)) & msk(k));
      return r;
   endfunction

   function automatic logic [39:0] rand_paddr();
      return {8'($urandom_range(0, 1)), 32'($urandom)};
   endfunction

   // Advances one clock on the main DUT and keeps the scoreboard in step with handshakes.
   task automatic tick();
      logic in_fire, out_fire;
      txn_t t;
      in_fire  = ifc.v_i && ifc.ready_and_o;
      out_fire = ifc.v_o && ifc.ready_and_i;
      popped   = 1'b0;
      if (out_fire) begin
         pop_got = {ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o};
         pop_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         popped  = 1'b1;
         $display("txn out: dram=%0b daddr=%h slice=%0d bank=%0d data=%h",
                  pop_got.dram, pop_got.daddr, pop_got.slice, pop_got.bank, pop_got.data);
      end
      if (in_fire) begin
         t      = model(ifc.paddr_i, tb_mode, 1, 1, 2);
         t.data = ifc.data_i;
         exp_q.push_back(t);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_cfg(input int m);
      ifc.cfg_v_i    = 1'b1;
      ifc.cfg_mode_i = 2'(m);
      tick();
      ifc.cfg_v_i = 1'b0;
      tb_mode     = (m == 3) ? 1 : m;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 16 && ifc.busy_o; n++) tick();
      vec_cnt++;
      if (ifc.busy_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL wait_idle: busy_o=%b required 0 within 16 cycles", ifc.busy_o);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if ({ifc.v_o, ifc.ready_and_o, ifc.busy_o, ifc.mode_o} !== 5'b00001) begin
         err_cnt++;
         $display("FAIL reset_ctrl: v/rdy/busy/mode=%b required 00001",
                  {ifc.v_o, ifc.ready_and_o, ifc.busy_o, ifc.mode_o});
      end
      vec_cnt++;
      if ({ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o} !== '0) begin
         err_cnt++;
         $display("FAIL reset_data: daddr=%h data=%h required 0", ifc.daddr_o, ifc.data_o);
      end
      #2 reset_n = 1'b1;
      #1;
      vec_cnt++;
      if (ifc.ready_and_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_release_early: ready_and_o=%b required 0", ifc.ready_and_o);
      end
      @(posedge clk);
      #1;
      vec_cnt++;
      if (ifc.ready_and_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_release_edge: ready_and_o=%b required 1", ifc.ready_and_o);
      end
   endtask

   task automatic test_mode1();
      logic [63:0] d;
      d = {32'($urandom), 32'($urandom)};
      ifc.ready_and_i = 1'b1;
      ifc.v_i = 1'b1;
      ifc.paddr_i = 40'h0_8000_3C40;
      ifc.data_i = d;
      vec_cnt++;
      if (ifc.v_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL mode1_pre: v_o=%b required 0", ifc.v_o);
      end
      tick();
      ifc.v_i = 1'b0;
      vec_cnt++;
      if ({ifc.v_o, ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o} !==
          {1'b1, 1'b1, 32'h8000_23C0, 1'b0, 2'd0, d}) begin
         err_cnt++;
         $display("FAIL mode1_vec: v=%b dram=%b daddr=%h slice=%0d bank=%0d required 1 1 800023c0 0 0",
                  ifc.v_o, ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o);
      end
      tick();
      vec_cnt++;
      if (!popped || pop_got !== pop_exp) begin
         err_cnt++;
         $display("FAIL mode1_sb: got %h required %h", pop_got, pop_exp);
      end
   endtask

   task automatic test_mode2();
      pulse_cfg(2);
      wait_idle();
      ifc.v_i = 1'b1;
      ifc.paddr_i = 40'h0_8000_3C40;
      ifc.data_i = 64'h1111_2222_3333_4444;
      tick();
      ifc.paddr_i = 40'h0_0020_0040;
      ifc.data_i = 64'h5555_6666_7777_8888;
      vec_cnt++;
      if ({ifc.v_o, ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o} !==
          {1'b1, 1'b1, 32'h8000_21C0, 1'b0, 2'd0}) begin
         err_cnt++;
         $display("FAIL mode2_vec: dram=%b daddr=%h slice=%0d bank=%0d required 1 800021c0 0 0",
                  ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o);
      end
      tick();
      ifc.v_i = 1'b0;
      vec_cnt++;
      if ({ifc.v_o, ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o} !==
          {1'b1, 1'b0, 32'h0020_0040, 1'b0, 2'd0, 64'h5555_6666_7777_8888}) begin
         err_cnt++;
         $display("FAIL mode2_nondram: dram=%b daddr=%h slice=%0d bank=%0d required 0 00200040 0 0",
                  ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o);
      end
      tick();
      vec_cnt++;
      if (!popped || pop_got !== pop_exp) begin
         err_cnt++;
         $display("FAIL mode2_sb: got %h required %h", pop_got, pop_exp);
      end
   endtask

   task automatic test_back_to_back();
      txn_t head;
      logic acc;
      int pops;
      ifc.ready_and_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ifc.v_i = 1'b1;
         ifc.paddr_i = {9'h001, 31'($urandom)};
         ifc.data_i = {32'($urandom), 32'($urandom)};
         vec_cnt++;
         if (ifc.ready_and_o !== (i < 2)) begin
            err_cnt++;
            $display("FAIL bp_ready[%0d]: ready_and_o=%b required %b", i, ifc.ready_and_o, i < 2);
         end
         tick();
      end
      head = exp_q[0];
      for (int i = 0; i < 2; i++) begin
         vec_cnt++;
         if ({ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o} !== head ||
             ifc.v_o !== 1'b1 || ifc.ready_and_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_hold[%0d]: v=%b rdy=%b got %h required %h", i, ifc.v_o,
                     ifc.ready_and_o,
                     {ifc.dram_o, ifc.daddr_o, ifc.slice_o, ifc.bank_o, ifc.data_o}, head);
         end
         tick();
      end
      ifc.ready_and_i = 1'b1;
      vec_cnt++;
      if (ifc.ready_and_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL bp_full_deq: ready_and_o=%b required 0", ifc.ready_and_o);
      end
      pops = 0;
      for (int n = 0; n < 12 && (ifc.v_i || exp_q.size() > 0); n++) begin
         acc = ifc.v_i && ifc.ready_and_o;
         tick();
         if (acc) ifc.v_i = 1'b0;
         if (popped) begin
            pops++;
            vec_cnt++;
            if (pop_got !== pop_exp) begin
               err_cnt++;
               $display("FAIL bp_order: got %h required %h", pop_got, pop_exp);
            end
         end
      end
      vec_cnt++;
      if (pops != 3) begin
         err_cnt++;
         $display("FAIL bp_count: %0d outputs required 3", pops);
      end
   endtask

   task automatic test_mode_switch();
      int pops;
      pulse_cfg(1);
      wait_idle();
      ifc.ready_and_i = 1'b0;
      ifc.v_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ifc.paddr_i = {9'h001, 31'($urandom)};
         ifc.data_i = {32'($urandom), 32'($urandom)};
         tick();
      end
      ifc.v_i = 1'b0;
      pulse_cfg(0);
      ifc.ready_and_i = 1'b1;
      pops = 0;
      for (int n = 0; n < 10 && ifc.v_o; n++) begin
         vec_cnt++;
         if (ifc.busy_o !== 1'b1 || ifc.ready_and_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL sw_drain: busy=%b rdy=%b required 1 0", ifc.busy_o, ifc.ready_and_o);
         end
         tick();
         if (popped) begin
            pops++;
            vec_cnt++;
            if (pop_got !== pop_exp) begin
               err_cnt++;
               $display("FAIL sw_old_mode: got %h required %h", pop_got, pop_exp);
            end
         end
      end
      vec_cnt++;
      if (pops != 2 || ifc.mode_o !== 2'd1 || ifc.busy_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL sw_empty: pops=%0d mode=%0d busy=%b required 2 1 1", pops, ifc.mode_o,
                  ifc.busy_o);
      end
      tick();
      vec_cnt++;
      if ({ifc.mode_o, ifc.busy_o, ifc.ready_and_o} !== 4'b0010) begin
         err_cnt++;
         $display("FAIL sw_swap: mode/busy/rdy=%b required 0010",
                  {ifc.mode_o, ifc.busy_o, ifc.ready_and_o});
      end
      tick();
      vec_cnt++;
      if ({ifc.busy_o, ifc.ready_and_o} !== 2'b01) begin
         err_cnt++;
         $display("FAIL sw_run: busy/rdy=%b required 01", {ifc.busy_o, ifc.ready_and_o});
      end
      ifc.v_i = 1'b1;
      ifc.paddr_i = 40'h0_8000_3C40;
      ifc.data_i = 64'hCAFE;
      tick();
      ifc.v_i = 1'b0;
      vec_cnt++;
      if ({ifc.v_o, ifc.dram_o, ifc.daddr_o} !== {1'b1, 1'b1, 32'h8000_3C40}) begin
         err_cnt++;
         $display("FAIL sw_mode0_vec: v=%b dram=%b daddr=%h required 1 1 80003c40", ifc.v_o,
                  ifc.dram_o, ifc.daddr_o);
      end
      tick();
   endtask

   task automatic test_random();
      logic pulse;
      int   m;
      for (int n = 0; n < 400; n++) begin
         ifc.v_i = 1'($urandom_range(0, 1));
         ifc.ready_and_i = ($urandom_range(0, 3) != 0);
         ifc.paddr_i = rand_paddr();
         ifc.data_i = {32'($urandom), 32'($urandom)};
         pulse = ($urandom_range(0, 24) == 0);
         m = $urandom_range(0, 3);
         ifc.cfg_v_i = pulse;
         ifc.cfg_mode_i = 2'(m);
         tick();
         ifc.cfg_v_i = 1'b0;
         if (pulse) tb_mode = (m == 3) ? 1 : m;
         if (popped) begin
            vec_cnt++;
            if (pop_got !== pop_exp) begin
               err_cnt++;
               $display("FAIL rand_sb[%0d]: got %h required %h", n, pop_got, pop_exp);
            end
         end
      end
      ifc.v_i = 1'b0;
      ifc.ready_and_i = 1'b1;
      for (int n = 0; n < 40 && (exp_q.size() > 0 || ifc.busy_o); n++) begin
         tick();
         if (popped) begin
            vec_cnt++;
            if (pop_got !== pop_exp) begin
               err_cnt++;
               $display("FAIL rand_drain: got %h required %h", pop_got, pop_exp);
            end
         end
      end
      vec_cnt++;
      if (exp_q.size() != 0 || ifc.v_o !== 1'b0 || ifc.busy_o !== 1'b0 ||
          ifc.mode_o !== 2'(tb_mode)) begin
         err_cnt++;
         $display("FAIL rand_end: left=%0d v=%b busy=%b mode=%0d required 0 0 0 %0d",
                  exp_q.size(), ifc.v_o, ifc.busy_o, ifc.mode_o, tb_mode);
      end
   endtask

   task automatic test_zero_width();
      logic [39:0] p;
      logic [63:0] d;
      txn_t e, g;
      int zmode;
      zmode = 1;
      ifz.ready_and_i = 1'b1;
      ifz.v_i = 1'b1;
      ifz.paddr_i = 40'h0_8000_05C0;
      ifz.data_i = 64'h0;
      @(posedge clk);
      #1;
      vec_cnt++;
      if ({ifz.v_o, ifz.dram_o, ifz.daddr_o, ifz.slice_o, ifz.bank_o} !==
          {1'b1, 1'b1, 32'h8000_0740, 1'b0, 2'd3}) begin
         err_cnt++;
         $display("FAIL zw_directed: daddr=%h slice=%0d bank=%0d required 80000740 0 3",
                  ifz.daddr_o, ifz.slice_o, ifz.bank_o);
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            p = rand_paddr();
            d = {32'($urandom), 32'($urandom)};
            ifz.v_i = 1'b1;
            ifz.paddr_i = p;
            ifz.data_i = d;
            @(posedge clk);
            #1;
            e = model(p, zmode, 0, 0, 2);
            e.data = d;
            g = {ifz.dram_o, ifz.daddr_o, ifz.slice_o, ifz.bank_o, ifz.data_o};
            $display("txn zw: mode=%0d paddr=%h daddr=%h bank=%0d", zmode, p, g.daddr, g.bank);
            vec_cnt++;
            if (ifz.v_o !== 1'b1 || g !== e) begin
               err_cnt++;
               $display("FAIL zw_stream[%0d.%0d]: v=%b got %h required %h", pass, i, ifz.v_o, g, e);
            end
         end
         if (pass == 0) begin
            ifz.v_i = 1'b0;
            ifz.cfg_v_i = 1'b1;
            ifz.cfg_mode_i = 2'd2;
            @(posedge clk);
            #1;
            ifz.cfg_v_i = 1'b0;
            for (int n = 0; n < 10 && ifz.busy_o; n++) begin
               @(posedge clk);
               #1;
            end
            zmode = 2;
            vec_cnt++;
            if (ifz.busy_o !== 1'b0 || ifz.mode_o !== 2'd2) begin
               err_cnt++;
               $display("FAIL zw_switch: busy=%b mode=%0d required 0 2", ifz.busy_o, ifz.mode_o);
            end
         end
      end
      #2 reset_n = 1'b0;
      #1;
      vec_cnt++;
      if ({ifz.v_o, ifz.ready_and_o, ifz.daddr_o} !== '0) begin
         err_cnt++;
         $display("FAIL zw_async_reset: v=%b rdy=%b daddr=%h required 0 0 0", ifz.v_o,
                  ifz.ready_and_o, ifz.daddr_o);
      end
      ifz.v_i = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      tb_mode = 1;
      vec_cnt++;
      if ({ifz.v_o, ifz.ready_and_o, ifz.mode_o, ifc.v_o} !== 5'b01010) begin
         err_cnt++;
         $display("FAIL zw_after_reset: v/rdy/mode/main_v=%b required 01010",
                  {ifz.v_o, ifz.ready_and_o, ifz.mode_o, ifc.v_o});
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      tb_mode = 1;
      popped = 1'b0;
      reset_n = 1'b0;
      ifc.cfg_v_i = 1'b0; ifc.cfg_mode_i = 2'd0; ifc.v_i = 1'b0;
      ifc.paddr_i = '0;   ifc.data_i = '0;       ifc.ready_and_i = 1'b1;
      ifz.cfg_v_i = 1'b0; ifz.cfg_mode_i = 2'd0; ifz.v_i = 1'b0;
      ifz.paddr_i = '0;   ifz.data_i = '0;       ifz.ready_and_i = 1'b1;
      test_reset();
      test_mode1();
      test_mode2();
      test_back_to_back();
      test_mode_switch();
      test_random();
      test_zero_width();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
